ram_block_copy: RTL and testbench
=================================

// Module: ram_block_copy
// PURPOSE
//  Responder on the controller's enable/acknowledge RAM-sharing handshake: while granted the RAM, copies LENGTH words
//  from a source region to a destination region of main memory, then raises acknowledge. Sits beside the other RAM
//  clients (draw, save, CPU) behind the controller's address/data/write-enable mux; single-port synchronous RAM.
// PARAMETERS
//  ADDR_W   11  RAM word-address width
//  DATA_W   32  RAM data width
// PORTS
//  CLOCK_50        in   1          system clock, all state on rising edge
//  resetIn         in   1          asynchronous, active-low reset
//  enable          in   1          grant from controller; level, held high until acknowledge seen
//  acknowledge     out  1          job finished; held high while enable stays high
//  srcBase         in   ADDR_W     first source word address (sampled at start)
//  dstBase         in   ADDR_W     first destination word address (sampled at start)
//  length          in   ADDR_W+1   words to copy, 0..2^ADDR_W (sampled at start)
//  dataRead        in   DATA_W     RAM q; valid the cycle after address is presented
//  address         out  ADDR_W     RAM address
//  dataWrite       out  DATA_W     RAM write data
//  writeEnableRam  out  1          RAM write strobe, one cycle per word
//  checksum        out  DATA_W     running sum of copied words (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; acknowledge, writeEnableRam=0; address, dataWrite, checksum=0; counters/latched bases cleared.
//  States: IDLE -> READ -> LATCH -> WRITE -> (READ | DONE); DONE -> IDLE.
//  IDLE: outputs 0. enable=1 -> latch srcBase/dstBase/length, idx=0; length==0 -> DONE, else READ.
//  READ: address=src+idx, writeEnableRam=0 -> LATCH.
//  LATCH: capture dataRead into word register -> WRITE.
//  WRITE: address=dst+idx, dataWrite=word, writeEnableRam=1; idx+1; idx+1==length -> DONE else READ.
//  DONE: acknowledge=1, writeEnableRam=0; remains until enable=0, then IDLE (acknowledge low the following cycle).
//  Throughput: exactly 3 cycles per word; ack first high 3*length+1 cycles after enable sampled (length=0: 1 cycle).
//  Address arithmetic modulo 2^ADDR_W: regions wrap past top of RAM silently (e.g. 0x7FF+1 -> 0x000).
//  Copy order strictly ascending; overlapping regions with dst>src propagate already-copied data (defined, not fixed up).
//  enable dropped mid-copy: abort same edge -> IDLE; no further writes; words already written stay; ack never raised.
//  enable re-asserted after abort or after DONE->IDLE: fresh job, inputs resampled, checksum cleared.
//  srcBase/dstBase/length changes during a job ignored. Async reset mid-copy: immediate return to reset values.
//  address/dataWrite/writeEnableRam are combinational from state + registers (controller muxes them same cycle).
// CONFIGURATION
//  RAM_COPY_CHECKSUM_EN defined: checksum cleared at job start, += word on each WRITE (mod 2^DATA_W); holds value
//   through DONE and IDLE until next job start.
//  Not defined: adder removed; checksum tied to 0. Handshake timing identical either way.
// TESTING
//  1 RAM[0x010..0x013]={1,2,3,4}, src=0x010,dst=0x400,len=4, enable -> RAM[0x400..0x403]={1,2,3,4}; ack at cycle 13;
//    4 write strobes; checksum=10 (EN) / 0 (no EN).
//  2 len=0, enable -> ack next cycle, zero write strobes, RAM unchanged; drop enable -> ack low 1 cycle later.
//  3 src=0x7FE,dst=0x100,len=3 -> reads 0x7FE,0x7FF,0x000; writes 0x100..0x102; no out-of-range address.
//  4 len=8, drop enable after 2nd write strobe -> no more strobes, ack stays 0, dst[2..7] untouched; re-enable
//    with len=1 completes normally.
//  5 Assert resetIn=0 during WRITE -> writeEnableRam, address, ack 0 same cycle; resumes IDLE; ack held while
//    enable high for 10 cycles after DONE.

Source files
------------

// File: rtl/ram_block_copy.sv
// RAM block copier: while granted the shared RAM, copies length words from srcBase to dstBase, then acknowledges.
// Optional running checksum of copied words when RAM_COPY_CHECKSUM_EN is defined; otherwise checksum is tied to 0.
module ram_block_copy #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              CLOCK_50,
    input  logic              resetIn,
    input  logic              enable,
    output logic              acknowledge,
    input  logic [ADDR_W-1:0] srcBase,
    input  logic [ADDR_W-1:0] dstBase,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] dataRead,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataWrite,
    output logic              writeEnableRam,
    output logic [DATA_W-1:0] checksum,
    output logic [2:0]        state_dbg
);

    // Handshake: enable is a level grant held until acknowledge is seen; acknowledge stays high
    // while enable stays high, and dropping enable at any point returns the block to IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                ack_q, ack_d;
    logic [ADDR_W:0]     idx_inc;
    logic                job_start;
    logic                word_written;

    assign idx_inc = idx_q + IDX_ONE;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        idx_d        = idx_q;
        word_d       = word_q;
        job_start    = 1'b0;
        word_written = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    job_start = 1'b1;
                    src_d     = srcBase;
                    dst_d     = dstBase;
                    len_d     = length;
                    idx_d     = '0;
                    state_d   = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = enable ? S_LATCH : S_IDLE;
            end
            S_LATCH: begin
                if (enable) begin
                    word_d  = dataRead;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                // The strobe for this word is already on the bus this cycle, so it counts as written.
                word_written = 1'b1;
                idx_d        = idx_inc;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (idx_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ack_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            ack_q   <= ack_d;
        end
    end

`ifdef RAM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (job_start) begin
            sum_d = '0;
        end else if (word_written) begin
            sum_d = sum_q + word_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_sum_ctl;
    assign unused_sum_ctl = job_start ^ word_written;
    assign checksum       = '0;
`endif

    // Bus outputs are decoded from state so the controller can mux them in the same cycle.
    always_comb begin
        address        = '0;
        dataWrite      = '0;
        writeEnableRam = 1'b0;
        case (state_q)
            S_READ: begin
                address = src_q + idx_q[ADDR_W-1:0];
            end
            S_WRITE: begin
                address        = dst_q + idx_q[ADDR_W-1:0];
                dataWrite      = word_q;
                writeEnableRam = 1'b1;
            end
            default: begin
                address        = '0;
                dataWrite      = '0;
                writeEnableRam = 1'b0;
            end
        endcase
    end

    assign acknowledge = ack_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ram_block_copy.sv
// Bench for ram_block_copy: behavioural RAM, expected write/read queues checked by a monitor, directed jobs.
module tb_ram_block_copy;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int W = ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              acknowledge;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W:0]   length;
  logic [DATA_W-1:0] data_read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_write;
  logic              we;
  logic [DATA_W-1:0] checksum;
  logic [2:0]        state_dbg;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int wr_cnt = 0;

  ram_block_copy #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50(clk), .resetIn(rst_n), .enable(enable), .acknowledge(acknowledge),
    .srcBase(src_base), .dstBase(dst_base), .length(length), .dataRead(data_read),
    .address(address), .dataWrite(data_write), .writeEnableRam(we), .checksum(checksum),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port synchronous RAM model
  always @(posedge clk) begin
    if (we) mem[address] <= data_write;
    data_read <= mem[address];
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write_strobe", {21'd0, address}, 32'hFFFF_FFFF);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("write_addr", {21'd0, address}, {21'd0, e[W-1:DATA_W]});
          check("write_data", data_write, e[DATA_W-1:0]);
        end
      end
      if (state_dbg == 3'd1) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", {21'd0, address}, 32'hFFFF_FFFF);
        end else begin
          logic [ADDR_W-1:0] r;
          r = rd_q.pop_front();
          check("read_addr", {21'd0, address}, {21'd0, r});
        end
      end
    end
  end

  // driver tasks
  task automatic start_job(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int n);
    @(negedge clk);
    src_base = s;
    dst_base = d;
    length   = n[ADDR_W:0];
    enable   = 1'b1;
  endtask

  task automatic expect_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] sa, da;
      sa = s + i[ADDR_W-1:0];
      da = d + i[ADDR_W-1:0];
      rd_q.push_back(sa);
      exp_q.push_back({da, mem[sa]});
    end
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!acknowledge && cyc < 200);
  endtask

  task automatic release_enable(input string name);
    enable = 1'b0;
    @(negedge clk);
    check(name, {31'd0, acknowledge}, 32'd0);
  endtask

  function automatic logic [DATA_W-1:0] exp_sum(input logic [DATA_W-1:0] s);
`ifdef RAM_COPY_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  initial begin
    int cyc;
    int base;
    int ack_low;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    rst_n = 1'b0; enable = 1'b0; src_base = '0; dst_base = '0; length = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, acknowledge}, 32'd0);
    check("reset_we", {31'd0, we}, 32'd0);
    check("reset_addr", {21'd0, address}, 32'd0);
    check("reset_wdata", data_write, 32'd0);
    check("reset_checksum", checksum, 32'd0);
    check("reset_state", {29'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic four-word copy
    mem[11'h010] = 32'd1; mem[11'h011] = 32'd2; mem[11'h012] = 32'd3; mem[11'h013] = 32'd4;
    base = wr_cnt;
    expect_copy(11'h010, 11'h400, 4);
    start_job(11'h010, 11'h400, 4);
    wait_ack(cyc);
    check("t1_ack_cycle", cyc, 32'd13);
    check("t1_strobes", wr_cnt - base, 32'd4);
    check("t1_checksum", checksum, exp_sum(32'd10));
    for (int i = 0; i < 4; i++) check("t1_dst_word", mem[11'h400 + i], i + 1);
    release_enable("t1_ack_drop");

    // 2: zero length
    base = wr_cnt;
    start_job(11'h020, 11'h420, 0);
    wait_ack(cyc);
    check("t2_ack_cycle", cyc, 32'd1);
    check("t2_strobes", wr_cnt - base, 32'd0);
    check("t2_checksum", checksum, 32'd0);
    release_enable("t2_ack_drop");

    // 3: source region wraps past top of RAM
    mem[11'h7FE] = 32'hA; mem[11'h7FF] = 32'hB; mem[11'h000] = 32'hC;
    expect_copy(11'h7FE, 11'h100, 3);
    start_job(11'h7FE, 11'h100, 3);
    wait_ack(cyc);
    check("t3_ack_cycle", cyc, 32'd10);
    check("t3_checksum", checksum, exp_sum(32'h21));
    check("t3_dst0", mem[11'h100], 32'hA);
    check("t3_dst2", mem[11'h102], 32'hC);
    release_enable("t3_ack_drop");

    // 4: abort after the second write strobe, then a fresh one-word job
    for (int i = 0; i < 8; i++) begin
      mem[11'h200 + i] = 32'h100 + i;
      mem[11'h300 + i] = 32'hDEAD_0000 + i;
    end
    base = wr_cnt;
    expect_copy(11'h200, 11'h300, 2);
    start_job(11'h200, 11'h300, 8);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (wr_cnt - base < 2 && cyc < 100);
    enable = 1'b0;
    ack_low = 0;
    repeat (30) begin
      @(negedge clk);
      if (acknowledge) ack_low++;
    end
    check("t4_ack_never", ack_low, 32'd0);
    check("t4_strobes", wr_cnt - base, 32'd2);
    check("t4_state_idle", {29'd0, state_dbg}, 32'd0);
    for (int i = 2; i < 8; i++) check("t4_untouched", mem[11'h300 + i], 32'hDEAD_0000 + i);
    expect_copy(11'h205, 11'h310, 1);
    start_job(11'h205, 11'h310, 1);
    wait_ack(cyc);
    check("t4_reenable_cycle", cyc, 32'd4);
    check("t4_reenable_data", mem[11'h310], 32'h105);
    check("t4_checksum", checksum, exp_sum(32'h105));
    release_enable("t4_ack_drop");

    // 5: asynchronous reset during WRITE, then ack held while enable stays high
    base = wr_cnt;
    expect_copy(11'h010, 11'h500, 1);
    start_job(11'h010, 11'h500, 4);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (wr_cnt == base && cyc < 100);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_we", {31'd0, we}, 32'd0);
    check("t5_rst_addr", {21'd0, address}, 32'd0);
    check("t5_rst_ack", {31'd0, acknowledge}, 32'd0);
    check("t5_rst_state", {29'd0, state_dbg}, 32'd0);
    check("t5_rst_checksum", checksum, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_one_strobe", wr_cnt - base, 32'd1);
    check("t5_untouched", mem[11'h501], 32'd0);
    expect_copy(11'h012, 11'h510, 2);
    start_job(11'h012, 11'h510, 2);
    wait_ack(cyc);
    check("t5_ack_cycle", cyc, 32'd7);
    ack_low = 0;
    repeat (10) begin
      @(negedge clk);
      if (!acknowledge) ack_low++;
    end
    check("t5_ack_held", ack_low, 32'd0);
    check("t5_checksum", checksum, exp_sum(32'd7));
    release_enable("t5_ack_drop");

    repeat (3) @(negedge clk);
    check("writes_outstanding", exp_q.size(), 32'd0);
    check("reads_outstanding", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
